// File: rtl/axi4s_counter_checker.sv
// AXI4-Stream sink that checks an incrementing counter stream: data continuity, TSTRB and TLAST
// framing, with beat/error statistics and optional LFSR-driven TREADY throttling.
module axi4s_counter_checker #(
   parameter int unsigned C_S00_AXIS_TDATA_WIDTH = 64,
   parameter int unsigned FRAME_LEN              = 256
) (
   input  logic                                  s00_axis_aclk,
   input  logic                                  s00_axis_aresetn,
   input  logic                                  s00_axis_tvalid,
   input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]     s00_axis_tdata,
   input  logic [C_S00_AXIS_TDATA_WIDTH/8-1:0]   s00_axis_tstrb,
   input  logic                                  s00_axis_tlast,
   output logic                                  s00_axis_tready,
   input  logic                                  clear,
   input  logic                                  throttle_en,
   output logic                                  locked,
   output logic [31:0]                           beat_count,
   output logic [15:0]                           error_count,
   output logic [2:0]                            err_flags,
   output logic [C_S00_AXIS_TDATA_WIDTH-1:0]     first_err_data,
   output logic [C_S00_AXIS_TDATA_WIDTH-1:0]     first_err_expected
);

   localparam int unsigned W  = C_S00_AXIS_TDATA_WIDTH;
   localparam int unsigned SW = W / 8;
   localparam logic [W-1:0] DataOne = W'(1);
   localparam logic [31:0]  LastIdx = 32'(FRAME_LEN - 1);

   typedef enum logic {StUnlocked, StLocked} state_e;

   state_e        state_q, state_d;
   logic          tready_q, tready_d;
   logic [15:0]   lfsr_q, lfsr_d;
   logic [W-1:0]  expected_q, expected_d;
   logic [31:0]   idx_q, idx_d;
   logic [31:0]   beat_count_q, beat_count_d;
   logic [15:0]   error_count_q, error_count_d;
   logic [2:0]    err_flags_q, err_flags_d;
   logic [W-1:0]  first_err_data_q, first_err_data_d;
   logic [W-1:0]  first_err_expected_q, first_err_expected_d;

   logic accept, data_err, strb_err, last_err, at_end;

   always_comb begin
      // x^16 + x^14 + x^13 + x^11, shifting toward bit 0
      lfsr_d   = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
      tready_d = throttle_en ? lfsr_q[0] : 1'b1;

      accept   = s00_axis_tvalid & tready_q;
      data_err = accept && (state_q == StLocked) && (s00_axis_tdata != expected_q);
      strb_err = accept && (s00_axis_tstrb != {SW{1'b1}});
      at_end   = 1'b0;
      last_err = 1'b0;
      if (FRAME_LEN > 0) begin
         at_end   = (idx_q == LastIdx);
         last_err = accept & (s00_axis_tlast ^ at_end);
      end

      state_d              = state_q;
      expected_d           = expected_q;
      idx_d                = idx_q;
      beat_count_d         = beat_count_q;
      error_count_d        = error_count_q;
      err_flags_d          = err_flags_q;
      first_err_data_d     = first_err_data_q;
      first_err_expected_d = first_err_expected_q;

      if (clear) begin
         // A beat handshaken in this cycle is dropped entirely
         state_d              = StUnlocked;
         expected_d           = '0;
         idx_d                = '0;
         beat_count_d         = '0;
         error_count_d        = '0;
         err_flags_d          = '0;
         first_err_data_d     = '0;
         first_err_expected_d = '0;
      end else if (accept) begin
         state_d      = StLocked;
         expected_d   = s00_axis_tdata + DataOne;
         beat_count_d = beat_count_q + 32'd1;
         if (FRAME_LEN > 0) begin
            idx_d = (s00_axis_tlast | at_end) ? 32'd0 : idx_q + 32'd1;
         end
         if (data_err | strb_err | last_err) begin
            if (error_count_q != 16'hFFFF) begin
               error_count_d = error_count_q + 16'd1;
            end
            err_flags_d = err_flags_q | {last_err, strb_err, data_err};
         end
         if (data_err && !err_flags_q[0]) begin
            first_err_data_d     = s00_axis_tdata;
            first_err_expected_d = expected_q;
         end
      end
   end

   always_ff @(posedge s00_axis_aclk) begin
      if (!s00_axis_aresetn) begin
         state_q              <= StUnlocked;
         tready_q             <= 1'b0;
         lfsr_q               <= 16'hACE1;
         expected_q           <= '0;
         idx_q                <= '0;
         beat_count_q         <= '0;
         error_count_q        <= '0;
         err_flags_q          <= '0;
         first_err_data_q     <= '0;
         first_err_expected_q <= '0;
      end else begin
         state_q              <= state_d;
         tready_q             <= tready_d;
         lfsr_q               <= lfsr_d;
         expected_q           <= expected_d;
         idx_q                <= idx_d;
         beat_count_q         <= beat_count_d;
         error_count_q        <= error_count_d;
         err_flags_q          <= err_flags_d;
         first_err_data_q     <= first_err_data_d;
         first_err_expected_q <= first_err_expected_d;
      end
   end

   assign s00_axis_tready    = tready_q;
   assign locked             = (state_q == StLocked);
   assign beat_count         = beat_count_q;
   assign error_count        = error_count_q;
   assign err_flags          = err_flags_q;
   assign first_err_data     = first_err_data_q;
   assign first_err_expected = first_err_expected_q;

endmodule

// File: tb/tb_axi4s_counter_checker.sv
// Directed bench for axi4s_counter_checker: per-beat expected statistics go through a scoreboard
// queue and are compared after each accepted beat.
module tb_axi4s_counter_checker;

   logic        clk = 1'b0;
   logic        aresetn = 1'b0;
   logic        tvalid = 1'b0;
   logic [63:0] tdata = '0;
   logic [7:0]  tstrb = 8'hFF;
   logic        tlast = 1'b0;
   logic        tready;
   logic        clear = 1'b0;
   logic        throttle_en = 1'b0;
   logic        locked;
   logic [31:0] beat_count;
   logic [15:0] error_count;
   logic [2:0]  err_flags;
   logic [63:0] first_err_data;
   logic [63:0] first_err_expected;

   always #5 clk = ~clk;

   axi4s_counter_checker #(
      .C_S00_AXIS_TDATA_WIDTH (64),
      .FRAME_LEN              (256)
   ) dut (
      .s00_axis_aclk      (clk),
      .s00_axis_aresetn   (aresetn),
      .s00_axis_tvalid    (tvalid),
      .s00_axis_tdata     (tdata),
      .s00_axis_tstrb     (tstrb),
      .s00_axis_tlast     (tlast),
      .s00_axis_tready    (tready),
      .clear              (clear),
      .throttle_en        (throttle_en),
      .locked             (locked),
      .beat_count         (beat_count),
      .error_count        (error_count),
      .err_flags          (err_flags),
      .first_err_data     (first_err_data),
      .first_err_expected (first_err_expected)
   );

   typedef struct {
      logic [31:0] beats;
      logic [15:0] errs;
      logic [2:0]  flags;
   } exp_t;

   exp_t        sb[$];
   int          checks = 0;
   int          errors = 0;
   int          low_cycles = 0;
   logic [31:0] m_beats = '0;
   logic [15:0] m_errs = '0;
   logic [2:0]  m_flags = '0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_zero();
      m_beats = '0;
      m_errs  = '0;
      m_flags = '0;
      sb.delete();
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_beats"}, 64'(beat_count), 64'd0);
      chk({tag, "_errs"}, 64'(error_count), 64'd0);
      chk({tag, "_flags"}, 64'(err_flags), 64'd0);
      chk({tag, "_locked"}, 64'(locked), 64'd0);
   endtask

   // Called at a negedge; e is the error set the test expects this beat to raise.
   task automatic send_beat(input logic [63:0] d, input logic [7:0] s, input logic l,
                            input logic [2:0] e);
      logic hs;
      int   guard;
      exp_t x, y;
      hs     = 1'b0;
      guard  = 0;
      tvalid = 1'b1;
      tdata  = d;
      tstrb  = s;
      tlast  = l;
      while (!hs && guard < 200) begin
         hs = tready;
         if (!hs) low_cycles++;
         @(posedge clk);
         if (hs) begin
            m_beats = m_beats + 32'd1;
            if (e != 3'b000) begin
               if (m_errs != 16'hFFFF) m_errs = m_errs + 16'd1;
               m_flags = m_flags | e;
            end
            x.beats = m_beats;
            x.errs  = m_errs;
            x.flags = m_flags;
            sb.push_back(x);
         end
         @(negedge clk);
         guard++;
      end
      tvalid = 1'b0;
      if (!hs) begin
         chk("handshake_timeout", 64'(hs), 64'd1);
      end else begin
         y = sb.pop_front();
         chk("beat_count", 64'(beat_count), 64'(y.beats));
         chk("error_count", 64'(error_count), 64'(y.errs));
         chk("err_flags", 64'(err_flags), 64'(y.flags));
         chk("locked", 64'(locked), 64'd1);
      end
   endtask

   task automatic do_clear(input logic v);
      tvalid = v;
      clear  = 1'b1;
      @(negedge clk);
      clear  = 1'b0;
      tvalid = 1'b0;
      model_zero();
      chk_zero("clear");
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int fi;

      // Reset held with a valid source: nothing may be accepted
      tvalid = 1'b1;
      repeat (4) @(negedge clk);
      chk("reset_tready", 64'(tready), 64'd0);
      chk_zero("reset");
      aresetn = 1'b1;
      @(negedge clk);
      chk("release_tready", 64'(tready), 64'd1);
      chk("release_locked", 64'(locked), 64'd0);
      tvalid = 1'b0;

      // Clean stream with framing
      for (int i = 0; i < 512; i++) begin
         send_beat(64'(i), 8'hFF, (i % 256) == 255, 3'b000);
      end
      chk("stream_beats", 64'(beat_count), 64'd512);

      // Single skip costs one error
      do_clear(1'b0);
      send_beat(64'd0, 8'hFF, 1'b0, 3'b000);
      send_beat(64'd1, 8'hFF, 1'b0, 3'b000);
      send_beat(64'd2, 8'hFF, 1'b0, 3'b000);
      send_beat(64'd7, 8'hFF, 1'b0, 3'b001);
      send_beat(64'd8, 8'hFF, 1'b0, 3'b000);
      chk("first_err_data", first_err_data, 64'd7);
      chk("first_err_expected", first_err_expected, 64'd3);

      // Wrap of the counter is legal
      do_clear(1'b0);
      chk("clear_first_err_data", first_err_data, 64'd0);
      chk("clear_first_err_exp", first_err_expected, 64'd0);
      send_beat(64'hFFFF_FFFF_FFFF_FFFE, 8'hFF, 1'b0, 3'b000);
      send_beat(64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b0, 3'b000);
      send_beat(64'd0, 8'hFF, 1'b0, 3'b000);
      send_beat(64'd1, 8'hFF, 1'b0, 3'b000);

      // Early TLAST resynchronises the frame; then a partial strobe
      do_clear(1'b0);
      for (int i = 0; i < 357; i++) begin
         send_beat(64'(i), 8'hFF, (i == 100) || (i == 356), (i == 100) ? 3'b100 : 3'b000);
      end
      send_beat(64'd357, 8'h0F, 1'b0, 3'b010);
      chk("strb_last_flags", 64'(err_flags), 64'b110);
      chk("strb_last_errs", 64'(error_count), 64'd2);

      // Reset mid-frame: no partial-frame error afterwards
      aresetn = 1'b0;
      @(negedge clk);
      aresetn = 1'b1;
      model_zero();
      chk_zero("midframe_reset");
      @(negedge clk);
      for (int i = 0; i < 256; i++) begin
         send_beat(64'(1000 + i), 8'hFF, i == 255, 3'b000);
      end

      // Throttled backpressure with a clear in the middle of the stream
      do_clear(1'b0);
      throttle_en = 1'b1;
      low_cycles  = 0;
      fi          = 0;
      for (int i = 0; i < 5000; i++) begin
         if (i == 2500) begin
            do_clear(1'b1);
            fi = 0;
         end
         send_beat(64'(5000 + i), 8'hFF, fi == 255, 3'b000);
         fi = (fi == 255) ? 0 : fi + 1;
      end
      chk("throttle_seen", 64'(low_cycles > 0), 64'd1);
      chk("throttle_beats", 64'(beat_count), 64'd2500);
      throttle_en = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
